// File: rtl/stream_router.sv
// stream_router: packet-level 1-to-N demux. Each packet is routed by the id on its
// first beat and stays on that route until last. There is one output register slot.
// Ports: clk_i, rst_n (async low), s_* input stream (data/qos/id/last/valid/ready),
//        m_* per-port output streams (unpacked data/qos, packed last/valid/ready).
// Option: STREAM_ROUTER_DROP_CNT_EN adds drop_cnt_o, a saturating count of illegal-id packets.
module stream_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
`ifdef STREAM_ROUTER_DROP_CNT_EN
  output logic [15:0]             drop_cnt_o,
`endif
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [STREAM_COUNT-1:0],
  output logic [T_QOS__WIDTH-1:0] m_qos_o  [STREAM_COUNT-1:0],
  output logic [STREAM_COUNT-1:0] m_last_o,
  output logic [STREAM_COUNT-1:0] m_valid_o,
  input  logic [STREAM_COUNT-1:0] m_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_e;

  // One extra bit so STREAM_COUNT itself is representable in the compare.
  localparam logic [T_ID___WIDTH:0] SC =
    (T_ID___WIDTH+1)'(STREAM_COUNT);

  state_e                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q, data_d;
  logic [T_QOS__WIDTH-1:0] qos_q, qos_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;
  logic [T_ID___WIDTH-1:0] dest_q, dest_d;
  logic [T_ID___WIDTH-1:0] pkt_dest_q, pkt_dest_d;

  logic id_ok;
  logic accept;
  logic out_hs;
  logic load;
  logic [T_ID___WIDTH-1:0] ld_dest;

  assign id_ok  = {1'b0, s_id_i} < SC;
  assign out_hs = valid_q && m_ready_i[dest_q];
  // The slot frees up in the same cycle it hands off, so no bubble.
  assign s_ready_o = (state_q == DROP) || !valid_q || m_ready_i[dest_q];
  assign accept = s_valid_i && s_ready_o;

  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    load       = 1'b0;
    ld_dest    = pkt_dest_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (id_ok) begin
            load       = 1'b1;
            ld_dest    = s_id_i;
            pkt_dest_d = s_id_i;
            state_d    = s_last_i ? IDLE : FWD;
          end else begin
            state_d = s_last_i ? IDLE : DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load = 1'b1;
          if (s_last_i) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && s_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    qos_d   = qos_q;
    last_d  = last_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = s_data_i;
      qos_d   = s_qos_i;
      last_d  = s_last_i;
      dest_d  = ld_dest;
      valid_d = 1'b1;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      qos_q      <= '0;
      last_q     <= 1'b0;
      dest_q     <= '0;
      valid_q    <= 1'b0;
      pkt_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      qos_q      <= qos_d;
      last_q     <= last_d;
      dest_q     <= dest_d;
      valid_q    <= valid_d;
      pkt_dest_q <= pkt_dest_d;
    end
  end

  always_comb begin
    for (int k = 0; k < STREAM_COUNT; k++) begin
      m_data_o[k]  = data_q;
      m_qos_o[k]   = qos_q;
      m_valid_o[k] = valid_q && (dest_q == T_ID___WIDTH'(k));
      m_last_o[k]  = last_q && (dest_q == T_ID___WIDTH'(k));
    end
  end

`ifdef STREAM_ROUTER_DROP_CNT_EN
  logic        drop_first;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Only first beats count, so a packet is counted once.
  assign drop_first = accept && (state_q == IDLE) && !id_ok;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_first && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_router.sv
// tb_stream_router: directed vector table, reset sequences and a random run
// against a packet-level queue model of stream_router (3 ports, id 3 illegal).
module tb_stream_router;

  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic [3:0] s_qos;
  logic [1:0] s_id;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data [SC-1:0];
  logic [3:0] m_qos  [SC-1:0];
  logic [2:0] m_last;
  logic [2:0] m_valid;
  logic [2:0] m_ready;
`ifdef STREAM_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_router #(
    .T_DATA_WIDTH(8),
    .T_QOS__WIDTH(4),
    .STREAM_COUNT(SC)
  ) dut (
    .clk_i    (clk),
    .rst_n    (rst_n),
`ifdef STREAM_ROUTER_DROP_CNT_EN
    .drop_cnt_o(drop_cnt),
`endif
    .s_data_i (s_data),
    .s_qos_i  (s_qos),
    .s_id_i   (s_id),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_qos_o  (m_qos),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [1:0] id, logic [7:0] d,
                       logic l, logic [2:0] rdy);
    s_valid = v;
    s_id    = id;
    s_data  = d;
    s_qos   = d[3:0];
    s_last  = l;
    m_ready = rdy;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] id;
    logic [7:0] d;
    logic       l;
    logic [2:0] rdy;
    logic       er;
    logic [2:0] ev;
    logic [7:0] ed;
    logic [2:0] el;
  } vec_t;

  vec_t tv [28];

  typedef struct {
    logic [1:0] dest;
    logic [7:0] d;
    logic [3:0] q;
    logic       l;
  } beat_t;

  beat_t sb [$];
  logic       in_pkt;
  logic       dropping;
  logic [1:0] pdest;
  int         drops;

  // Checks the current cycle against the model, then advances the model
  // by whatever transfers happen at the coming edge.
  task automatic step();
    logic       er;
    logic [2:0] ev;
    logic [2:0] el;
    beat_t      b;
    er = dropping || sb.size() == 0 || m_ready[sb[0].dest];
    ev = 3'b000;
    el = 3'b000;
    if (sb.size() != 0) begin
      ev = 3'b001 << sb[0].dest;
      el = sb[0].l ? ev : 3'b000;
    end
    chk("rnd ready", 32'(s_ready), 32'(er));
    chk("rnd valid", 32'(m_valid), 32'(ev));
    if (sb.size() != 0) begin
      chk("rnd data", 32'(m_data[sb[0].dest]), 32'(sb[0].d));
      chk("rnd qos", 32'(m_qos[sb[0].dest]), 32'(sb[0].q));
      chk("rnd last", 32'(m_last), 32'(el));
      if (m_ready[sb[0].dest]) void'(sb.pop_front());
    end
    if (s_valid && er) begin
      b.d = s_data;
      b.q = s_qos;
      b.l = s_last;
      if (!in_pkt) begin
        if (32'(s_id) < SC) begin
          pdest = s_id;
          b.dest = s_id;
          sb.push_back(b);
          dropping = 1'b0;
        end else begin
          drops++;
          dropping = !s_last;
        end
        in_pkt = !s_last;
      end else begin
        if (!dropping) begin
          b.dest = pdest;
          sb.push_back(b);
        end
        if (s_last) begin
          in_pkt   = 1'b0;
          dropping = 1'b0;
        end
      end
    end
  endtask

  initial begin
    tv[0]  = '{1'b1,2'd1,8'd11,1'b0,3'b111, 1'b1,3'b000,8'd0, 3'b000};
    tv[1]  = '{1'b1,2'd1,8'd12,1'b0,3'b111, 1'b1,3'b010,8'd11,3'b000};
    tv[2]  = '{1'b1,2'd1,8'd13,1'b0,3'b111, 1'b1,3'b010,8'd12,3'b000};
    tv[3]  = '{1'b1,2'd1,8'd14,1'b1,3'b111, 1'b1,3'b010,8'd13,3'b000};
    tv[4]  = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b010,8'd14,3'b010};
    tv[5]  = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b000,8'd14,3'b010};
    tv[6]  = '{1'b1,2'd0,8'd21,1'b1,3'b111, 1'b1,3'b000,8'd14,3'b010};
    tv[7]  = '{1'b1,2'd1,8'd22,1'b0,3'b111, 1'b1,3'b001,8'd21,3'b001};
    tv[8]  = '{1'b1,2'd1,8'd23,1'b1,3'b111, 1'b1,3'b010,8'd22,3'b000};
    tv[9]  = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b010,8'd23,3'b010};
    tv[10] = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b000,8'd23,3'b010};
    tv[11] = '{1'b1,2'd1,8'd31,1'b0,3'b111, 1'b1,3'b000,8'd23,3'b010};
    tv[12] = '{1'b1,2'd0,8'd32,1'b0,3'b111, 1'b1,3'b010,8'd31,3'b000};
    tv[13] = '{1'b1,2'd0,8'd33,1'b1,3'b111, 1'b1,3'b010,8'd32,3'b000};
    tv[14] = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b010,8'd33,3'b010};
    tv[15] = '{1'b1,2'd0,8'd41,1'b0,3'b111, 1'b1,3'b000,8'd33,3'b010};
    tv[16] = '{1'b1,2'd0,8'd42,1'b0,3'b110, 1'b0,3'b001,8'd41,3'b000};
    tv[17] = '{1'b1,2'd0,8'd42,1'b0,3'b110, 1'b0,3'b001,8'd41,3'b000};
    tv[18] = '{1'b1,2'd0,8'd42,1'b0,3'b110, 1'b0,3'b001,8'd41,3'b000};
    tv[19] = '{1'b1,2'd0,8'd42,1'b0,3'b111, 1'b1,3'b001,8'd41,3'b000};
    tv[20] = '{1'b1,2'd0,8'd43,1'b1,3'b111, 1'b1,3'b001,8'd42,3'b000};
    tv[21] = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b001,8'd43,3'b001};
    tv[22] = '{1'b1,2'd3,8'd51,1'b0,3'b111, 1'b1,3'b000,8'd43,3'b001};
    tv[23] = '{1'b1,2'd0,8'd52,1'b0,3'b000, 1'b1,3'b000,8'd43,3'b001};
    tv[24] = '{1'b1,2'd0,8'd53,1'b1,3'b000, 1'b1,3'b000,8'd43,3'b001};
    tv[25] = '{1'b1,2'd2,8'd54,1'b1,3'b111, 1'b1,3'b000,8'd43,3'b001};
    tv[26] = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b100,8'd54,3'b100};
    tv[27] = '{1'b0,2'd0,8'd0, 1'b0,3'b111, 1'b1,3'b000,8'd54,3'b100};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'd0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset valid", 32'(m_valid), 32'd0);
    chk("reset last", 32'(m_last), 32'd0);
    chk("reset data", 32'(m_data[1]), 32'd0);
    chk("reset qos", 32'(m_qos[2]), 32'd0);
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      drive(tv[i].v, tv[i].id, tv[i].d, tv[i].l, tv[i].rdy);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(s_ready), 32'(tv[i].er));
      chk($sformatf("row%0d valid", i), 32'(m_valid), 32'(tv[i].ev));
      chk($sformatf("row%0d last", i), 32'(m_last), 32'(tv[i].el));
      for (int k = 0; k < SC; k++) begin
        chk($sformatf("row%0d data%0d", i, k), 32'(m_data[k]), 32'(tv[i].ed));
        chk($sformatf("row%0d qos%0d", i, k), 32'(m_qos[k]), 32'(tv[i].ed[3:0]));
      end
    end
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("drop_cnt after id3", 32'(drop_cnt), 32'd1);
`endif

    // Async reset with the slot full mid-packet.
    @(posedge clk);
    #1;
    drive(1'b1, 2'd1, 8'd61, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    drive(1'b1, 2'd1, 8'd62, 1'b0, 3'b000);
    @(negedge clk);
    chk("pre-reset valid", 32'(m_valid), 32'b010);
    chk("pre-reset ready", 32'(s_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(m_valid), 32'd0);
    chk("async reset data", 32'(m_data[1]), 32'd0);
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("async reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 8'd63, 1'b1, 3'b111);
    @(negedge clk);
    chk("post-reset ready", 32'(s_ready), 32'd1);
    chk("post-reset valid0", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 8'd0, 1'b0, 3'b111);
    @(negedge clk);
    chk("post-reset valid1", 32'(m_valid), 32'b100);
    chk("post-reset data", 32'(m_data[2]), 32'd63);
    chk("post-reset last", 32'(m_last), 32'b100);

    // Random run from a clean reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    in_pkt   = 1'b0;
    dropping = 1'b0;
    pdest    = 2'd0;
    drops    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      drive(($urandom % 4) != 0, 2'($urandom % 4), 8'($urandom),
            ($urandom % 3) == 0,
            {($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0});
      s_qos = 4'($urandom);
      @(negedge clk);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 2'd0, 8'd0, 1'b0, 3'b111);
      @(negedge clk);
      step();
    end
    chk("drain empty", 32'(sb.size()), 32'd0);
`ifdef STREAM_ROUTER_DROP_CNT_EN
    chk("rnd drop_cnt", 32'(drop_cnt), 32'(drops));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
